// File: rtl/console_arbiter_pkg.sv
// Shared types and constants for the four-way console arbiter.
package console_arbiter_pkg;

  localparam int unsigned num_req = 4;
  localparam int unsigned grant_w = 2;
  localparam int unsigned count_w = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Zero-based requester index: 0 = in1 ... 3 = in4.
  typedef logic [grant_w-1:0] grant_t;

  // After reset the search starts just past in4, so in1 has first priority.
  localparam grant_t last_grant_rst = grant_t'(num_req - 1);

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first active request after last_grant, wrapping.
module rr_pick
  import console_arbiter_pkg::*;
(
  input  logic [num_req-1:0] req,
  input  grant_t             last_grant,
  output grant_t             grant,
  output logic               valid
);

  grant_t idx;

  // Walk last_grant+1 .. last_grant+4 (mod 4) and take the first hit.
  always_comb begin
    grant = last_grant;
    valid = 1'b0;
    idx   = last_grant;
    for (int unsigned i = 1; i <= num_req; i++) begin
      idx = last_grant + grant_t'(i);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/console_arbiter.sv
// Four requesters share one console output; a grant is held until a
// terminator word or max_words words have been forwarded.
module console_arbiter
  import console_arbiter_pkg::*;
#(
  parameter int unsigned bits       = 16,
  parameter int unsigned terminator = 10,
  parameter int unsigned max_words  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] in1,
  input  logic [bits-1:0] in2,
  input  logic [bits-1:0] in3,
  input  logic [bits-1:0] in4,
  input  logic            in1_stb,
  input  logic            in2_stb,
  input  logic            in3_stb,
  input  logic            in4_stb,
  output logic            in1_ack,
  output logic            in2_ack,
  output logic            in3_ack,
  output logic            in4_ack,
  output logic [bits-1:0] out1,
  output logic            out1_stb,
  input  logic            out1_ack
);

  state_t              state, state_n;
  logic [num_req-1:0]  ack_q, ack_n, stb_v;
  logic [bits-1:0]     out_q, out_n, word_sel;
  logic                out_stb_q, out_stb_n;
  grant_t              grant_q, grant_n, last_q, last_n, pick;
  logic                pick_valid;
  logic [count_w-1:0]  count_q, count_n, count_inc;
  logic                release_grant;

  assign stb_v = {in4_stb, in3_stb, in2_stb, in1_stb};

  rr_pick u_rr_pick (
    .req        (stb_v),
    .last_grant (last_q),
    .grant      (pick),
    .valid      (pick_valid)
  );

  // Data word of the currently granted requester.
  always_comb begin
    case (grant_q)
      2'd0:    word_sel = in1;
      2'd1:    word_sel = in2;
      2'd2:    word_sel = in3;
      default: word_sel = in4;
    endcase
  end

  // The held word ends the grant if it is the terminator or fills the quota.
  assign count_inc     = count_q + count_w'(1);
  assign release_grant = (out_q == bits'(terminator)) ||
                         (count_inc == count_w'(max_words));

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    ack_n     = ack_q;
    out_n     = out_q;
    out_stb_n = out_stb_q;
    count_n   = count_q;
    grant_n   = grant_q;
    last_n    = last_q;
    case (state)
      IDLE: begin
        ack_n   = '0;
        count_n = '0;
        if (pick_valid) begin
          grant_n     = pick;
          ack_n[pick] = 1'b1;
          state_n     = LOCKED;
        end
      end
      LOCKED: begin
        if (stb_v[grant_q] && ack_q[grant_q]) begin
          out_n     = word_sel;
          out_stb_n = 1'b1;
          ack_n     = '0;
          state_n   = SEND;
        end
      end
      SEND: begin
        if (out1_ack) begin
          out_stb_n = 1'b0;
          if (release_grant) begin
            count_n = '0;
            last_n  = grant_q;
            state_n = IDLE;
          end else begin
            count_n        = count_inc;
            ack_n[grant_q] = 1'b1;
            state_n        = LOCKED;
          end
        end
      end
      default: begin
        ack_n     = '0;
        out_stb_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ack_q     <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
      count_q   <= '0;
      grant_q   <= last_grant_rst;
      last_q    <= last_grant_rst;
    end else begin
      state     <= state_n;
      ack_q     <= ack_n;
      out_q     <= out_n;
      out_stb_q <= out_stb_n;
      count_q   <= count_n;
      grant_q   <= grant_n;
      last_q    <= last_n;
    end
  end

  assign in1_ack  = ack_q[0];
  assign in2_ack  = ack_q[1];
  assign in3_ack  = ack_q[2];
  assign in4_ack  = ack_q[3];
  assign out1     = out_q;
  assign out1_stb = out_stb_q;

endmodule

// File: tb/tb_console_arbiter.sv
// Bench for console_arbiter: three instances (max_words 64, 3, 1) run the
// same requester traffic against a message-level reference model.
module tb_console_arbiter;

  localparam int nd = 3;

  typedef struct packed {
    int          own;   // 0 = nobody, else requester 1..4
    logic        hv;    // a word is waiting for the console
    logic [15:0] w;     // last word taken
    int          sent;  // words forwarded in this grant
    int          last;  // last released requester 1..4
  } mstate_t;

  logic        clk, rst;
  logic [15:0] din  [nd][4];
  logic        stb  [nd][4];
  logic        ack  [nd][4];
  logic [15:0] dout [nd];
  logic        dstb [nd];
  logic        dack [nd];

  mstate_t     m [nd];
  logic [15:0] qbuf [nd][4][64];
  int          hd [nd][4];
  int          tl [nd][4];
  logic        took [nd][4];
  int          ack_cyc [nd][4];
  int          log_s [nd][256];
  logic [15:0] log_w [nd][256];
  int          logn [nd] = '{0, 0, 0};
  int          last_src [nd] = '{0, 0, 0};
  int          base [nd];
  int          npush;
  int          oack_mode;
  logic        gap;
  int          n_checks = 0;
  int          n_fail = 0;

  for (genvar g = 0; g < nd; g++) begin : g_dut
    console_arbiter #(
      .bits       (16),
      .terminator (10),
      .max_words  (g == 0 ? 64 : (g == 1 ? 3 : 1))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in1      (din[g][0]),
      .in2      (din[g][1]),
      .in3      (din[g][2]),
      .in4      (din[g][3]),
      .in1_stb  (stb[g][0]),
      .in2_stb  (stb[g][1]),
      .in3_stb  (stb[g][2]),
      .in4_stb  (stb[g][3]),
      .in1_ack  (ack[g][0]),
      .in2_ack  (ack[g][1]),
      .in3_ack  (ack[g][2]),
      .in4_ack  (ack[g][3]),
      .out1     (dout[g]),
      .out1_stb (dstb[g]),
      .out1_ack (dack[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mw_of(input int d);
    return (d == 0) ? 64 : ((d == 1) ? 3 : 1);
  endfunction

  // One clock of the message-level rules: grant, take a word, hand it on.
  function automatic mstate_t step(input mstate_t c, input logic [3:0] sv,
                                   input logic [3:0][15:0] dv,
                                   input logic oack, input int mw);
    mstate_t n = c;
    int k;
    if (c.own == 0) begin
      for (int j = 1; j <= 4; j++) begin
        k = (c.last + j - 1) % 4 + 1;
        if (n.own == 0 && sv[k-1]) n.own = k;
      end
    end else if (!c.hv) begin
      if (sv[c.own-1]) begin
        n.hv = 1'b1;
        n.w  = dv[c.own-1];
      end
    end else if (oack) begin
      n.hv   = 1'b0;
      n.sent = c.sent + 1;
      if (c.w == 16'd10 || n.sent == mw) begin
        n.last = c.own;
        n.own  = 0;
        n.sent = 0;
      end
    end
    return n;
  endfunction

  // Reference model state, advanced on the same edges as the DUTs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < nd; d++) m[d] <= '{own: 0, hv: 1'b0, w: 16'd0, sent: 0, last: 4};
    end else begin
      for (int d = 0; d < nd; d++)
        m[d] <= step(m[d], {stb[d][3], stb[d][2], stb[d][1], stb[d][0]},
                     {din[d][3], din[d][2], din[d][1], din[d][0]},
                     dack[d], mw_of(d));
    end
  end

  // Record each word delivered on out1 together with the requester it came from.
  always @(posedge clk) begin
    for (int d = 0; d < nd; d++) begin
      for (int i = 0; i < 4; i++)
        if (rst && ack[d][i] && stb[d][i]) last_src[d] <= i + 1;
      if (rst && dstb[d] && dack[d]) begin
        if (logn[d] < 256) begin
          log_w[d][logn[d]] <= dout[d];
          log_s[d][logn[d]] <= last_src[d];
        end
        logn[d] <= logn[d] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < nd; d++) begin
      for (int i = 0; i < 4; i++) begin
        stb[d][i] = (hd[d][i] < tl[d][i]) && (!gap || $urandom_range(0, 3) != 0);
        din[d][i] = (hd[d][i] < tl[d][i]) ? qbuf[d][i][hd[d][i]] : 16'($urandom);
      end
      dack[d] = (oack_mode == 2) ? 1'($urandom_range(0, 1)) : (oack_mode == 1);
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    for (int d = 0; d < nd; d++) begin
      if (tl[d][i] < 64) begin
        qbuf[d][i][tl[d][i]] = w;
        tl[d][i]++;
      end
    end
    npush++;
    drive();
  endtask

  // Compare every DUT with the model mid-cycle, then advance the sources.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < nd; d++) begin
      check($sformatf("d%0d out1_stb", d), 32'(dstb[d]), 32'(m[d].hv));
      check($sformatf("d%0d out1", d), 32'(dout[d]), 32'(m[d].w));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("d%0d in%0d_ack", d, i + 1), 32'(ack[d][i]),
              32'(m[d].own == i + 1 && !m[d].hv));
        took[d][i] = ack[d][i] && stb[d][i];
        if (ack[d][i]) ack_cyc[d][i]++;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < nd; d++)
      for (int i = 0; i < 4; i++)
        if (took[d][i]) hd[d][i]++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int d = 0; d < nd; d++)
      for (int i = 0; i < 4; i++) begin
        hd[d][i] = 0; tl[d][i] = 0; took[d][i] = 1'b0; ack_cyc[d][i] = 0;
      end
    drive();
    run(2);
    rst = 1'b1;
    for (int d = 0; d < nd; d++) base[d] = logn[d];
    npush = 0;
  endtask

  task automatic check_log(input int d, input int k, input int es, input int ew);
    check($sformatf("d%0d log[%0d] source", d, k), 32'(log_s[d][(base[d] + k) % 256]), 32'(es));
    check($sformatf("d%0d log[%0d] word", d, k), 32'(log_w[d][(base[d] + k) % 256]), 32'(ew));
  endtask

  task automatic wait_stb(input int d, input int maxc);
    int n = 0;
    while (!dstb[d] && n < maxc) begin
      tick();
      n++;
    end
    check($sformatf("d%0d out1_stb within %0d cycles", d, maxc), 32'(dstb[d]), 32'd1);
  endtask

  function automatic logic drained();
    for (int d = 0; d < nd; d++) begin
      if (dstb[d]) return 1'b0;
      for (int i = 0; i < 4; i++) if (hd[d][i] != tl[d][i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    int n;
    int es [7];
    int ew [7];
    oack_mode = 1;
    gap = 1'b0;
    do_reset();

    // Reset values.
    check("reset out1_stb", 32'(dstb[0]), 32'd0);
    check("reset out1", 32'(dout[0]), 32'd0);
    check("reset in1_ack", 32'(ack[0][0]), 32'd0);

    // Single requester message.
    push(0, 16'd72); push(0, 16'd105); push(0, 16'd10);
    run(15);
    check("single count", 32'(logn[0] - base[0]), 32'd3);
    check_log(0, 0, 1, 72); check_log(0, 1, 1, 105); check_log(0, 2, 1, 10);
    check("single in1_ack cycles", 32'(ack_cyc[0][0]), 32'd3);
    check("single idle stb", 32'(dstb[0]), 32'd0);
    check("single idle ack", 32'(ack[0][0]), 32'd0);

    // Two simultaneous requesters: whole messages, no interleaving.
    do_reset();
    push(0, 16'd65); push(0, 16'd10); push(1, 16'd66); push(1, 16'd10);
    run(20);
    check("pair count", 32'(logn[0] - base[0]), 32'd4);
    check_log(0, 0, 1, 65); check_log(0, 1, 1, 10);
    check_log(0, 2, 2, 66); check_log(0, 3, 2, 10);

    // Everyone busy: word-level round robin at max_words=1, stall when a grantee runs dry.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(i, 16'(100 + i));
      push(i, 16'(200 + i));
    end
    run(40);
    check("rr count mw1", 32'(logn[2] - base[2]), 32'd8);
    check_log(2, 0, 1, 100); check_log(2, 1, 2, 101); check_log(2, 2, 3, 102);
    check_log(2, 3, 4, 103); check_log(2, 4, 1, 200);
    check("stall count mw3", 32'(logn[1] - base[1]), 32'd2);
    check("stall grant held mw3", 32'(ack[1][0]), 32'd1);

    // Quota release at max_words=3 lets a waiting requester in.
    do_reset();
    for (int k = 1; k <= 5; k++) push(2, 16'(k));
    push(3, 16'd7); push(3, 16'd10);
    run(40);
    es = '{3, 3, 3, 4, 4, 3, 3};
    ew = '{1, 2, 3, 7, 10, 4, 5};
    check("quota count mw3", 32'(logn[1] - base[1]), 32'd7);
    for (int k = 0; k < 7; k++) check_log(1, k, es[k], ew[k]);

    // Console back-pressure holds the word stable.
    do_reset();
    oack_mode = 0;
    push(1, 16'd12345); push(1, 16'd10);
    wait_stb(0, 10);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("hold out1", 32'(dout[0]), 32'd12345);
      check("hold out1_stb", 32'(dstb[0]), 32'd1);
      check("hold in2_ack", 32'(ack[0][1]), 32'd0);
    end
    oack_mode = 1;
    drive();
    run(10);
    check("hold count", 32'(logn[0] - base[0]), 32'd2);
    check_log(0, 0, 2, 12345); check_log(0, 1, 2, 10);

    // Asynchronous reset during SEND.
    do_reset();
    oack_mode = 0;
    push(0, 16'd7);
    wait_stb(0, 10);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int d = 0; d < nd; d++) check($sformatf("d%0d async reset stb", d), 32'(dstb[d]), 32'd0);
    do_reset();
    oack_mode = 1;
    push(3, 16'd55); push(3, 16'd10); push(0, 16'd66); push(0, 16'd10);
    run(20);
    check("post reset count", 32'(logn[0] - base[0]), 32'd4);
    check_log(0, 0, 1, 66);
    check_log(0, 2, 4, 55);

    // Random traffic: terminated messages, random gaps and back-pressure.
    do_reset();
    oack_mode = 2;
    gap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int msg = 0; msg < 3; msg++) begin
        n = $urandom_range(1, 5);
        for (int k = 1; k < n; k++) begin
          logic [15:0] w;
          w = 16'($urandom);
          push(i, (w == 16'd10) ? 16'd11 : w);
        end
        push(i, 16'd10);
      end
    end
    n = 0;
    while (!drained() && n < 3000) begin
      tick();
      n++;
    end
    run(3);
    check("random traffic drained", 32'(drained()), 32'd1);
    for (int d = 0; d < nd; d++)
      check($sformatf("d%0d random word count", d), 32'(logn[d] - base[d]), 32'(npush));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
